// File: rtl/m2014_fsm_array_if.sv
// rtl/m2014_fsm_array_if.sv - per-channel control and status bundle for the FSM array
//
// Purpose: groups the per-lane inputs (en, w, clr) and the registered status
// outputs (state, z, z_rise, hit_cnt, any_z) of m2014_fsm_array.
// Ports (signals):
//   en      [NCH]        per-channel advance strobe
//   w       [NCH]        per-channel FSM input
//   clr     [NCH]        per-channel synchronous clear
//   state   [3*NCH]      channel i state at [3i+2:3i]
//   z       [NCH]        Moore output, 1 in E/F
//   z_rise  [NCH]        one-cycle pulse on entry into E/F
//   hit_cnt [CNT_W*NCH]  saturating entry counters
//   any_z   [1]          registered OR of all z
// Modports: master drives inputs and observes status; slave is the array.
interface m2014_fsm_array_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       w;
  logic [NCH-1:0]       clr;
  logic [3*NCH-1:0]     state;
  logic [NCH-1:0]       z;
  logic [NCH-1:0]       z_rise;
  logic [CNT_W*NCH-1:0] hit_cnt;
  logic                 any_z;

  modport master (
    output en, w, clr,
    input  state, z, z_rise, hit_cnt, any_z
  );

  modport slave (
    input  en, w, clr,
    output state, z, z_rise, hit_cnt, any_z
  );
endinterface

// File: rtl/m2014_fsm_array.sv
// rtl/m2014_fsm_array.sv - NCH independent six-state w-driven sequence FSMs with entry counters
//
// Purpose: each channel runs the A..F sequence FSM (z=1 in E/F), stepping only
// when en[i]=1. Entries into {E,F} from outside it raise a one-cycle z_rise
// and bump a saturating counter. Every output is a flop.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset, clears every channel
//   bus    slave modport of m2014_fsm_array_if (en, w, clr in; state, z,
//          z_rise, hit_cnt, any_z out)
module m2014_fsm_array #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               reset,
  m2014_fsm_array_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_A = 3'b000,
    ST_B = 3'b001,
    ST_C = 3'b010,
    ST_D = 3'b011,
    ST_E = 3'b100,
    ST_F = 3'b101
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic is_ef(input state_e s);
    return (s == ST_E) || (s == ST_F);
  endfunction

  logic [3*NCH-1:0]     state_q, state_d;
  logic [NCH-1:0]       z_q, z_d;
  logic [NCH-1:0]       z_rise_q, z_rise_d;
  logic [CNT_W*NCH-1:0] hit_cnt_q, hit_cnt_d;
  logic                 any_z_q, any_z_d;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [2:0]       cur_raw;
    state_e           cur_s;
    state_e           nxt_s;
    state_e           ch_state;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] ch_cnt;
    logic             ch_zr;
    logic             illegal;

    assign cur_raw = state_q[3*g +: 3];
    assign cur_s   = state_e'(cur_raw);
    assign cur_cnt = hit_cnt_q[CNT_W*g +: CNT_W];
    // 110 and 111 are not reachable states; they are flushed to A
    assign illegal = (cur_raw > 3'b101);

    always_comb begin
      nxt_s = ST_A;
      case (cur_s)
        ST_A:    nxt_s = bus.w[g] ? ST_A : ST_B;
        ST_B:    nxt_s = bus.w[g] ? ST_D : ST_C;
        ST_C:    nxt_s = bus.w[g] ? ST_D : ST_E;
        ST_D:    nxt_s = bus.w[g] ? ST_A : ST_F;
        ST_E:    nxt_s = bus.w[g] ? ST_D : ST_E;
        ST_F:    nxt_s = bus.w[g] ? ST_D : ST_C;
        default: nxt_s = ST_A;
      endcase
    end

    always_comb begin
      ch_state = cur_s;
      ch_cnt   = cur_cnt;
      ch_zr    = 1'b0;
      if (bus.clr[g]) begin
        ch_state = ST_A;
        ch_cnt   = '0;
      end else if (illegal) begin
        // recovery happens even with en low and is never an entry
        ch_state = ST_A;
      end else if (bus.en[g]) begin
        ch_state = nxt_s;
        // only C->E and D->F qualify; E->E and F/E->D are not entries
        if (!is_ef(cur_s) && is_ef(nxt_s)) begin
          ch_zr = 1'b1;
          if (cur_cnt != CNT_MAX) begin
            ch_cnt = cur_cnt + 1'b1;
          end
        end
      end
    end

    assign state_d[3*g +: 3]         = ch_state;
    assign hit_cnt_d[CNT_W*g +: CNT_W] = ch_cnt;
    assign z_rise_d[g]               = ch_zr;
    assign z_d[g]                    = is_ef(ch_state);
  end

  // any_z is an OR of the registered z, hence one cycle behind it
  assign any_z_d = |z_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '0;
      z_q       <= '0;
      z_rise_q  <= '0;
      hit_cnt_q <= '0;
      any_z_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      z_rise_q  <= z_rise_d;
      hit_cnt_q <= hit_cnt_d;
      any_z_q   <= any_z_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.z       = z_q;
  assign bus.z_rise  = z_rise_q;
  assign bus.hit_cnt = hit_cnt_q;
  assign bus.any_z   = any_z_q;

endmodule

// File: tb/tb_m2014_fsm_array.sv
// tb/tb_m2014_fsm_array.sv - scoreboard bench for m2014_fsm_array (wide-counter and 2-bit-counter instances)
module tb_m2014_fsm_array;

  localparam logic [2:0] SA = 3'd0, SB = 3'd1, SC = 3'd2, SD = 3'd3, SE = 3'd4, SF = 3'd5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  m2014_fsm_array_if #(.NCH(4), .CNT_W(8)) bus_a ();
  m2014_fsm_array_if #(.NCH(1), .CNT_W(2)) bus_b ();

  m2014_fsm_array #(.NCH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  m2014_fsm_array #(.NCH(1), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct {
    int         cyc;
    int         id;
    int         sel;
    int         ch;
    logic [2:0] st;
    logic       z;
    logic       zr;
    int         cnt;
    logic       chk_any;
    logic       any;
  } exp_t;

  exp_t sb[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   next_id = 0;

  task automatic step(input logic rst, input logic [3:0] aen, input logic [3:0] aw,
                      input logic [3:0] aclr, input logic ben, input logic bw);
    @(negedge clk);
    reset      = rst;
    bus_a.en   = aen;
    bus_a.w    = aw;
    bus_a.clr  = aclr;
    bus_b.en   = ben;
    bus_b.w    = bw;
    bus_b.clr  = 1'b0;
  endtask

  // expectation for the outputs after the next rising edge
  task automatic ex(input int sel, input int ch, input logic [2:0] st, input logic z,
                    input logic zr, input int cnt, input logic chk_any, input logic any);
    exp_t e;
    e.cyc = cyc + 1; e.id = next_id; e.sel = sel; e.ch = ch; e.st = st;
    e.z = z; e.zr = zr; e.cnt = cnt; e.chk_any = chk_any; e.any = any;
    next_id++;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [2:0] a_st;
    logic       a_z, a_zr, a_any;
    int         a_cnt;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.sel == 0) begin
          a_st  = bus_a.state[3*e.ch +: 3];
          a_z   = bus_a.z[e.ch];
          a_zr  = bus_a.z_rise[e.ch];
          a_cnt = int'(bus_a.hit_cnt[8*e.ch +: 8]);
          a_any = bus_a.any_z;
        end else begin
          a_st  = bus_b.state[2:0];
          a_z   = bus_b.z[0];
          a_zr  = bus_b.z_rise[0];
          a_cnt = int'(bus_b.hit_cnt[1:0]);
          a_any = bus_b.any_z;
        end
        n_chk++;
        if (e.cyc != cyc || a_st !== e.st || a_z !== e.z || a_zr !== e.zr ||
            a_cnt != e.cnt || (e.chk_any && a_any !== e.any)) begin
          n_fail++;
          $display("FAIL chk%0d dut%0d ch%0d cyc%0d: got st=%0d z=%b zr=%b cnt=%0d any=%b, want st=%0d z=%b zr=%b cnt=%0d any=%b (checked=%b, due cyc%0d)",
                   e.id, e.sel, e.ch, cyc, a_st, a_z, a_zr, a_cnt, a_any,
                   e.st, e.z, e.zr, e.cnt, e.any, e.chk_any, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: bench did not complete, %0d checks pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    bus_a.en = '0; bus_a.w = '0; bus_a.clr = '0;
    bus_b.en = '0; bus_b.w = '0; bus_b.clr = '0;

    // reset beats en on every channel
    step(1, 4'hF, 4'h5, 4'h0, 1, 0);
    step(1, 4'hF, 4'h5, 4'h0, 1, 0);
    for (int c = 0; c < 4; c++) ex(0, c, SA, 0, 0, 0, 1, 0);
    ex(1, 0, SA, 0, 0, 0, 1, 0);

    // ch0: A -> B -> C -> E, entry counted; any_z one cycle later
    step(0, 4'h1, 4'h0, 4'h0, 0, 0); ex(0, 0, SB, 0, 0, 0, 1, 0);
    step(0, 4'h1, 4'h0, 4'h0, 0, 0); ex(0, 0, SC, 0, 0, 0, 1, 0);
    step(0, 4'h1, 4'h0, 4'h0, 0, 0); ex(0, 0, SE, 1, 1, 1, 1, 0);

    // E self-loop, then D, then F (second entry)
    step(0, 4'h1, 4'h0, 4'h0, 0, 0); ex(0, 0, SE, 1, 0, 1, 1, 1);
    step(0, 4'h1, 4'h1, 4'h0, 0, 0); ex(0, 0, SD, 0, 0, 1, 1, 1);
    step(0, 4'h1, 4'h0, 4'h0, 0, 0); ex(0, 0, SF, 1, 1, 2, 1, 0);

    // en low with w toggling: everything frozen, z_rise low
    for (int i = 0; i < 5; i++) begin
      step(0, 4'h0, (i % 2 == 0) ? 4'hF : 4'h0, 4'h0, 0, 0);
      ex(0, 0, SF, 1, 0, 2, 1, 1);
    end
    step(0, 4'h1, 4'h1, 4'h0, 0, 0); ex(0, 0, SD, 0, 0, 2, 1, 1);
    step(0, 4'h1, 4'h1, 4'h0, 0, 0); ex(0, 0, SA, 0, 0, 2, 1, 0);
    step(0, 4'h1, 4'h1, 4'h0, 0, 0); ex(0, 0, SA, 0, 0, 2, 1, 0);

    // ch0 and ch1 in lockstep, then clr on ch1 only at the C->E step
    step(0, 4'h3, 4'h0, 4'h0, 0, 0); ex(0, 0, SB, 0, 0, 2, 1, 0); ex(0, 1, SB, 0, 0, 0, 0, 0);
    step(0, 4'h3, 4'h0, 4'h0, 0, 0); ex(0, 0, SC, 0, 0, 2, 1, 0); ex(0, 1, SC, 0, 0, 0, 0, 0);
    step(0, 4'h3, 4'h0, 4'h0, 0, 0); ex(0, 0, SE, 1, 1, 3, 1, 0); ex(0, 1, SE, 1, 1, 1, 0, 0);
    step(0, 4'h3, 4'h3, 4'h0, 0, 0); ex(0, 0, SD, 0, 0, 3, 1, 1); ex(0, 1, SD, 0, 0, 1, 0, 0);
    step(0, 4'h3, 4'h3, 4'h0, 0, 0); ex(0, 0, SA, 0, 0, 3, 1, 0); ex(0, 1, SA, 0, 0, 1, 0, 0);
    step(0, 4'h3, 4'h0, 4'h0, 0, 0); ex(0, 0, SB, 0, 0, 3, 1, 0); ex(0, 1, SB, 0, 0, 1, 0, 0);
    step(0, 4'h3, 4'h0, 4'h0, 0, 0); ex(0, 0, SC, 0, 0, 3, 1, 0); ex(0, 1, SC, 0, 0, 1, 0, 0);
    step(0, 4'h3, 4'h0, 4'h2, 0, 0); ex(0, 0, SE, 1, 1, 4, 1, 0); ex(0, 1, SA, 0, 0, 0, 0, 0);

    // ch0 to F with count 5, then reset overrides en and clr
    step(0, 4'h1, 4'h1, 4'h0, 0, 0); ex(0, 0, SD, 0, 0, 4, 1, 1); ex(0, 1, SA, 0, 0, 0, 0, 0);
    step(0, 4'h1, 4'h0, 4'h0, 0, 0); ex(0, 0, SF, 1, 1, 5, 1, 0);
    step(1, 4'hF, 4'h0, 4'h2, 0, 0); ex(0, 0, SA, 0, 0, 0, 1, 0); ex(0, 1, SA, 0, 0, 0, 0, 0);

    // illegal codes: ch0=110 with en low, ch2=111 with en high; both to A, uncounted
    step(0, 4'h4, 4'h0, 4'h0, 0, 0);
    force dut.state_q = 12'h1C6;
    #1;
    release dut.state_q;
    ex(0, 0, SA, 0, 0, 0, 1, 0);
    ex(0, 2, SA, 0, 0, 0, 0, 0);

    // 2-bit counter instance: four entries saturate at 3
    step(0, 4'h0, 4'h0, 4'h0, 1, 0); ex(1, 0, SB, 0, 0, 0, 1, 0);
    step(0, 4'h0, 4'h0, 4'h0, 1, 0); ex(1, 0, SC, 0, 0, 0, 1, 0);
    step(0, 4'h0, 4'h0, 4'h0, 1, 0); ex(1, 0, SE, 1, 1, 1, 1, 0);
    step(0, 4'h0, 4'h0, 4'h0, 1, 1); ex(1, 0, SD, 0, 0, 1, 1, 1);
    step(0, 4'h0, 4'h0, 4'h0, 1, 0); ex(1, 0, SF, 1, 1, 2, 1, 0);
    step(0, 4'h0, 4'h0, 4'h0, 1, 0); ex(1, 0, SC, 0, 0, 2, 1, 1);
    step(0, 4'h0, 4'h0, 4'h0, 1, 0); ex(1, 0, SE, 1, 1, 3, 1, 0);
    step(0, 4'h0, 4'h0, 4'h0, 1, 1); ex(1, 0, SD, 0, 0, 3, 1, 1);
    step(0, 4'h0, 4'h0, 4'h0, 1, 0); ex(1, 0, SF, 1, 1, 3, 1, 0);
    step(0, 4'h0, 4'h0, 4'h0, 0, 1); ex(1, 0, SF, 1, 0, 3, 1, 1);

    step(0, 4'h0, 4'h0, 4'h0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
